wf_write_arbiter: RTL and testbench

//  Shares the single wireframe frame-buffer write port between NUM_REQ rasterizer cores and a built-in frame-clear sweep.

---
 rtl/wf_write_arbiter_pkg.sv | 17 +
 rtl/wf_write_arbiter_rr_arbiter.sv | 33 +++
 rtl/wf_write_arbiter.sv | 105 ++++++++++
 tb/tb_wf_write_arbiter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/wf_write_arbiter_pkg.sv
// Shared types and defaults for the wireframe frame-buffer write arbiter.
package wf_write_arbiter_pkg;

  localparam int WIREFRAME_ADDR_SIZE = 10;
  localparam int WIREFRAME_DEPTH     = 768;

  typedef enum logic {
    ARB   = 1'b0,
    CLEAR = 1'b1
  } wf_arb_state_t;

  // Plot counter sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/wf_write_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: rotate requests by rr_ptr, pick the lowest, rotate back.
module rr_arbiter #(
  parameter  int NUM_REQ = 2,
  localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   grant_idx,
  output logic               any
);

  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;
  logic [PTR_W-1:0]     off;
  logic [PTR_W:0]       sum;

  assign any = |req;

  always_comb begin
    dbl = {req, req} >> rr_ptr;
    rot = dbl[NUM_REQ-1:0];
    off = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = i[PTR_W-1:0];
    end
    sum = {1'b0, rr_ptr} + {1'b0, off};
    if (sum >= (PTR_W+1)'(NUM_REQ)) sum = sum - (PTR_W+1)'(NUM_REQ);
    grant_idx = sum[PTR_W-1:0];
    grant     = any ? (NUM_REQ'(1) << grant_idx) : '0;
  end

endmodule

// File: rtl/wf_write_arbiter.sv
// Shares the wireframe frame-buffer write port between plot requesters and a clear sweep.
module wf_write_arbiter
  import wf_write_arbiter_pkg::*;
#(
  parameter int NUM_REQ  = 2,
  parameter int ADDR_W   = WIREFRAME_ADDR_SIZE,
  parameter int WF_DEPTH = WIREFRAME_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ-1:0]        req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      clear_start,
  output logic                      clear_busy,
  output logic                      clear_done,
  output logic                      write_en,
  output logic                      wf_data,
  output logic [ADDR_W-1:0]         addr,
  output logic [15:0]               plot_count
);

  localparam int          PTR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(WF_DEPTH - 1);

  wf_arb_state_t      state, state_nxt;
  logic [PTR_W-1:0]   rr_ptr;
  logic [ADDR_W-1:0]  clr_cnt;
  logic [NUM_REQ-1:0] grant;
  logic [PTR_W-1:0]   grant_idx;
  logic               any_req;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req       (req_valid),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (any_req)
  );

  // Clear wins over plots in the same cycle; no grants while reset is held.
  always_comb begin
    state_nxt = state;
    req_ready = '0;
    case (state)
      ARB: begin
        if (clear_start) state_nxt = CLEAR;
        else if (!rst)   req_ready = grant;
      end
      CLEAR: begin
        if (clr_cnt == CLR_LAST) state_nxt = ARB;
      end
      default: state_nxt = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ARB;
      rr_ptr     <= '0;
      clr_cnt    <= '0;
      write_en   <= 1'b0;
      wf_data    <= 1'b0;
      addr       <= '0;
      clear_busy <= 1'b0;
      clear_done <= 1'b0;
      plot_count <= '0;
    end else begin
      state      <= state_nxt;
      write_en   <= 1'b0;
      clear_busy <= 1'b0;
      clear_done <= 1'b0;
      case (state)
        ARB: begin
          if (clear_start) begin
            clr_cnt    <= '0;
            plot_count <= '0;
          end else if (any_req) begin
            write_en   <= 1'b1;
            addr       <= req_addr[grant_idx*ADDR_W +: ADDR_W];
            wf_data    <= req_data[grant_idx];
            rr_ptr     <= (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
            plot_count <= sat_inc16(plot_count);
          end
        end
        CLEAR: begin
          write_en   <= 1'b1;
          addr       <= clr_cnt;
          wf_data    <= 1'b0;
          clear_busy <= 1'b1;
          // The sweep stops at the last word, so the counter never wraps.
          if (clr_cnt == CLR_LAST) begin
            clear_done <= 1'b1;
            clr_cnt    <= '0;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wf_write_arbiter.sv
// Randomized and directed bench for wf_write_arbiter against a cycle-level behavioural model.
module tb_wf_write_arbiter;

  localparam int NUM_REQ  = 2;
  localparam int ADDR_W   = 10;
  localparam int WF_DEPTH = 16;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]        req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      clear_start;
  logic                      clear_busy;
  logic                      clear_done;
  logic                      write_en;
  logic                      wf_data;
  logic [ADDR_W-1:0]         addr;
  logic [15:0]               plot_count;

  int tests = 0;
  int fails = 0;

  // Model state: mode 0 = arbitrating, 1 = clearing.
  int m_mode = 0;
  int m_idx  = 0;
  int m_ptr  = 0;
  int m_cnt  = 0;
  int e_we = 0, e_addr = 0, e_data = 0, e_busy = 0, e_done = 0;
  int n_writes = 0;
  int n_done   = 0;

  wf_write_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .WF_DEPTH(WF_DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .clear_start (clear_start),
    .clear_busy  (clear_busy),
    .clear_done  (clear_done),
    .write_en    (write_en),
    .wf_data     (wf_data),
    .addr        (addr),
    .plot_count  (plot_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Inputs are already applied (after a negedge). Predict, clock once, compare at the next negedge.
  task automatic step();
    int g;
    logic [NUM_REQ-1:0] exp_ready;
    #1;
    g = -1;
    for (int k = 0; k < NUM_REQ; k++) begin
      int i;
      i = (m_ptr + k) % NUM_REQ;
      if (g < 0 && req_valid[i]) g = i;
    end
    exp_ready = '0;
    if (!rst && m_mode == 0 && !clear_start && g >= 0) exp_ready[g] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(exp_ready));

    e_busy = 0;
    e_done = 0;
    if (rst) begin
      m_mode = 0; m_idx = 0; m_ptr = 0; m_cnt = 0;
      e_we = 0; e_addr = 0; e_data = 0;
    end else if (m_mode == 0) begin
      if (clear_start) begin
        m_mode = 1; m_idx = 0; m_cnt = 0; e_we = 0;
      end else if (g >= 0) begin
        e_we   = 1;
        e_addr = int'(req_addr[g*ADDR_W +: ADDR_W]);
        e_data = int'(req_data[g]);
        m_ptr  = (g + 1) % NUM_REQ;
        m_cnt  = (m_cnt < 65535) ? m_cnt + 1 : 65535;
      end else begin
        e_we = 0;
      end
    end else begin
      e_we   = 1;
      e_addr = m_idx;
      e_data = 0;
      e_busy = 1;
      if (m_idx == WF_DEPTH - 1) begin
        e_done = 1;
        m_mode = 0;
      end else begin
        m_idx++;
      end
    end

    @(posedge clk);
    @(negedge clk);
    chk("write_en", 32'(write_en), 32'(e_we));
    chk("clear_busy", 32'(clear_busy), 32'(e_busy));
    chk("clear_done", 32'(clear_done), 32'(e_done));
    chk("plot_count", 32'(plot_count), 32'(m_cnt));
    if (e_we != 0) begin
      chk("addr", 32'(addr), 32'(e_addr));
      chk("wf_data", 32'(wf_data), 32'(e_data));
    end
    if (write_en) n_writes++;
    if (clear_done) n_done++;
  endtask

  initial begin
    rst         = 1'b1;
    req_valid   = '1;
    req_addr    = '0;
    req_data    = '0;
    clear_start = 1'b0;
    @(negedge clk);

    // Reset held three cycles with every requester valid
    for (int i = 0; i < 3; i++) step();
    chk("rst_addr", 32'(addr), 32'h0);
    chk("rst_wf_data", 32'(wf_data), 32'h0);
    rst = 1'b0;
    req_valid = '0;
    step();

    // Both requesters valid: grants alternate 0,1,0,1
    req_valid = 2'b11;
    req_addr  = {10'h020, 10'h010};
    req_data  = 2'b01;
    for (int i = 0; i < 4; i++) step();
    req_valid = '0;
    step();
    chk("plot_count_after_4", 32'(plot_count), 32'd4);

    // Clear colliding with pending plots; then plots resume
    req_valid   = 2'b11;
    clear_start = 1'b1;
    n_writes = 0; n_done = 0;
    step();
    clear_start = 1'b0;
    for (int i = 0; i < WF_DEPTH; i++) step();
    chk("clear_writes", 32'(n_writes), 32'(WF_DEPTH));
    chk("clear_done_count", 32'(n_done), 32'd1);
    chk("addr_at_done", 32'(addr), 32'(WF_DEPTH - 1));
    for (int i = 0; i < 3; i++) step();

    // Second clear_start during the sweep is ignored
    req_valid   = '0;
    clear_start = 1'b1;
    step();
    clear_start = 1'b0;
    n_writes = 0; n_done = 0;
    for (int i = 0; i < WF_DEPTH + 2; i++) begin
      clear_start = (i == 5);
      step();
    end
    clear_start = 1'b0;
    chk("reclear_writes", 32'(n_writes), 32'(WF_DEPTH));
    chk("reclear_done", 32'(n_done), 32'd1);

    // Reset in the middle of a sweep
    req_valid   = 2'b10;
    clear_start = 1'b1;
    step();
    clear_start = 1'b0;
    for (int i = 0; i < 7; i++) step();
    rst = 1'b1;
    n_done = 0;
    step();
    rst = 1'b0;
    chk("rst_mid_we", 32'(write_en), 32'h0);
    chk("rst_mid_busy", 32'(clear_busy), 32'h0);
    for (int i = 0; i < WF_DEPTH; i++) step();
    chk("rst_mid_no_done", 32'(n_done), 32'd0);

    // Randomized traffic with occasional clears and resets
    for (int i = 0; i < 600; i++) begin
      req_valid   = NUM_REQ'($urandom);
      req_addr    = (NUM_REQ*ADDR_W)'({$urandom, $urandom});
      req_data    = NUM_REQ'($urandom);
      clear_start = ($urandom_range(0, 39) == 0);
      rst         = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 1'b0;
    clear_start = 1'b0;

    // Saturation of plot_count: clear, then more than 65535 grants
    clear_start = 1'b1;
    req_valid   = '0;
    step();
    clear_start = 1'b0;
    for (int i = 0; i < WF_DEPTH; i++) step();
    req_valid = 2'b11;
    for (int i = 0; i < 65538; i++) step();
    chk("plot_count_sat", 32'(plot_count), 32'hFFFF);
    step();
    chk("plot_count_hold", 32'(plot_count), 32'hFFFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
